shader_dispatch: RTL
====================

Name: shader_dispatch

Overview:
- Schedules triangles across NUM_LANES parallel pixel-shader instances.
- Accepts triangles on a valid/ready input and broadcasts vertices on a shared registered bus. Issues one start pulse per lane, round-robin.
- Collects each lane's one-cycle color result and emits colors in original input order, tagged with a triangle ID.
- Sits between the triangle fetch/transform stage and the framebuffer writer.

Parameters:
- NUM_LANES, 4, number of shader instances (power of two, 2..16).
- ID_W, 8, width of triangle sequence ID (wraps modulo 2^ID_W).

Ports:
- clk_in  input  1  system clock.
- rst_in  input  1  synchronous, active-low reset (0 = reset).
- tri_valid_in  input  1  triangle available.
- tri_ready_out  output  1  dispatcher accepts triangle this cycle.
- v1_in, v2_in, v3_in  input  9 x3 each  unsigned vertex coords [0]=x, [1]=y, [2]=z.
- lane_start_out  output  NUM_LANES  one-hot, one-cycle start pulse to a shader (drives its data_valid_in).
- lane_v1_out, lane_v2_out, lane_v3_out  output  9 x3 each  shared registered vertex bus.
- lane_valid_in  input  NUM_LANES  per-lane result pulse (shader valid_out).
- lane_color_in  input  NUM_LANES x 8  per-lane color (shader color_out).
- color_valid_out  output  1  ordered result available.
- color_ready_in  input  1  downstream accepts result.
- color_out  output  8  shaded color.
- tri_id_out  output  ID_W  sequence ID of that triangle.
- err_out  output  1  sticky: result pulse from a lane not BUSY.

Behaviour:
- Reset (rst_in=0 at clock edge) drives all of the following to 0 and abandons any in-flight work: lane states IDLE, dispatch pointer dp, retire pointer rp, ID counter, lane_start_out, vertex bus, output register, color_valid_out, err_out. Shaders share the same reset (inverted at top level), so no stale results arrive afterwards.
- Per-lane FSM:
  - IDLE -> BUSY on dispatch.
  - BUSY -> DONE on lane_valid_in[i]; lane_color_in[i] is captured into res[i].
  - DONE -> IDLE on retire.
- tri_ready_out = rst_in & (state[dp]==IDLE). It is derived from registered state only.
- Dispatch (tri_valid_in & tri_ready_out):
  - Vertices are registered onto the bus.
  - lane_start_out[dp] is high the next cycle, for exactly one cycle.
  - id[dp] <= ID counter; ID counter increments and wraps; dp increments modulo NUM_LANES.
  - The vertex bus holds its value until the next dispatch.
- Back-to-back dispatch to different lanes is allowed, one per cycle. A lane busy at dp stalls input; dp never skips lanes.
- Output register:
  - Loads when state[rp]==DONE and (!color_valid_out | color_ready_in).
  - On load: color_out <= res[rp], tri_id_out <= id[rp]; lane rp goes IDLE; rp increments.
  - Full throughput under continuous ready.
- color_valid_out holds with stable data until accepted.
- Latency: a lane result pulse at cycle k gives color_valid_out at k+2 if that lane is rp and the output is free.
- Ordering: results always exit in dispatch order, even when later lanes finish first. Early finishers wait in DONE.
- A lane freed by retire in cycle t can be dispatched no earlier than t+1.
- lane_valid_in[i] while lane i is IDLE or DONE: the pulse is ignored, res[i] is unchanged, and err_out is set. err_out clears only on reset.
- Simultaneous result pulses from multiple lanes are all captured in the same cycle.

Optional Feature:
- Macro SHADER_DISPATCH_PERF_EN.
- When defined, adds outputs perf_tri_count_out (32) and perf_stall_count_out (32):
  - perf_tri_count_out counts dispatches.
  - perf_stall_count_out counts cycles with tri_valid_in=1 and tri_ready_out=0.
  - Both saturate at 2^32-1 and reset to 0.
- When undefined, these ports and counters do not exist and all other behaviour is identical.

Test Plan:
- Reset → all lanes IDLE, tri_ready_out=1, color_valid_out=0, err_out=0, lane_start_out=0.
- 4 triangles back-to-back, each lane returns after 5 cycles with colors 0x10..0x13 → lane_start_out pulses 0001,0010,0100,1000 on consecutive cycles; outputs 0x10..0x13 with IDs 0..3 in order.
- Out-of-order completion: lane 2 returns 0xAA before lane 0 returns 0x55 → 0x55 (id 0) emitted first, then lane 1's result, then 0xAA (id 2).
- Fifth triangle while lane 0 still BUSY → tri_ready_out=0 until lane 0 retires, then the fifth triangle goes to lane 0 with id 4. With perf enabled, the stall count equals the stalled cycles.
- color_ready_in=0 for 10 cycles with all lanes DONE → color_valid_out held, same color_out/tri_id_out, no retire; then 4 outputs on 4 consecutive cycles.
- Stray lane_valid_in[3] with lane 3 IDLE → err_out=1 and stays 1; no output generated. Reset mid-flight with 2 lanes BUSY → clean IDLE state and IDs restart at 0.

Source files
------------

// File: rtl/shader_dispatch_if.sv
// Triangle input and ordered color output handshakes of the shader dispatcher.
// The slave modport is the dispatcher; the master modport is the surrounding pipeline.
interface shader_dispatch_if #(
    parameter int ID_W = 8
);
    logic             tri_valid_in;
    logic             tri_ready_out;
    logic [2:0][8:0]  v1_in;
    logic [2:0][8:0]  v2_in;
    logic [2:0][8:0]  v3_in;
    logic             color_valid_out;
    logic             color_ready_in;
    logic [7:0]       color_out;
    logic [ID_W-1:0]  tri_id_out;

    modport master (
        output tri_valid_in, v1_in, v2_in, v3_in, color_ready_in,
        input  tri_ready_out, color_valid_out, color_out, tri_id_out
    );

    modport slave (
        input  tri_valid_in, v1_in, v2_in, v3_in, color_ready_in,
        output tri_ready_out, color_valid_out, color_out, tri_id_out
    );
endinterface

// File: rtl/shader_dispatch.sv
// Round-robin triangle dispatcher over NUM_LANES shader lanes with in-order color retire.
// Defining SHADER_DISPATCH_PERF_EN adds saturating dispatch and stall counters.
module shader_dispatch #(
    parameter int NUM_LANES = 4,
    parameter int ID_W      = 8
) (
    input  logic                       clk_in,
    input  logic                       rst_in,
    shader_dispatch_if.slave           bus,
    output logic [NUM_LANES-1:0]       lane_start_out,
    output logic [2:0][8:0]            lane_v1_out,
    output logic [2:0][8:0]            lane_v2_out,
    output logic [2:0][8:0]            lane_v3_out,
    input  logic [NUM_LANES-1:0]       lane_valid_in,
    input  logic [NUM_LANES-1:0][7:0]  lane_color_in,
    output logic                       err_out
`ifdef SHADER_DISPATCH_PERF_EN
    ,
    output logic [31:0]                perf_tri_count_out,
    output logic [31:0]                perf_stall_count_out
`endif
);
    localparam int LW = $clog2(NUM_LANES);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state [NUM_LANES];
    logic [7:0]      res   [NUM_LANES];
    logic [ID_W-1:0] id    [NUM_LANES];
    logic [LW-1:0]   dp;
    logic [LW-1:0]   rp;
    logic [ID_W-1:0] id_cnt;
    logic            dispatch;
    logic            retire;

    // Input is only ever offered to the lane at dp, so a busy lane stalls rather than being skipped.
    assign bus.tri_ready_out = rst_in & (state[dp] == ST_IDLE);
    assign dispatch          = bus.tri_valid_in & bus.tri_ready_out;
    assign retire            = (state[rp] == ST_DONE) & (~bus.color_valid_out | bus.color_ready_in);

    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            for (int i = 0; i < NUM_LANES; i++) begin
                state[i] <= ST_IDLE;
                res[i]   <= '0;
                id[i]    <= '0;
            end
            err_out <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_LANES; i++) begin
                case (state[i])
                    ST_IDLE: begin
                        if (dispatch && dp == LW'(i)) begin
                            state[i] <= ST_BUSY;
                            id[i]    <= id_cnt;
                        end
                    end
                    ST_BUSY: begin
                        if (lane_valid_in[i]) begin
                            state[i] <= ST_DONE;
                            res[i]   <= lane_color_in[i];
                        end
                    end
                    ST_DONE: begin
                        if (retire && rp == LW'(i)) begin
                            state[i] <= ST_IDLE;
                        end
                    end
                    default: state[i] <= ST_IDLE;
                endcase
                if (lane_valid_in[i] && state[i] != ST_BUSY) begin
                    err_out <= 1'b1;
                end
            end
        end
    end

    // Vertex bus and start pulse are registered; the output register refills while being drained.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            dp                  <= '0;
            rp                  <= '0;
            id_cnt              <= '0;
            lane_start_out      <= '0;
            lane_v1_out         <= '0;
            lane_v2_out         <= '0;
            lane_v3_out         <= '0;
            bus.color_valid_out <= 1'b0;
            bus.color_out       <= '0;
            bus.tri_id_out      <= '0;
        end else begin
            lane_start_out <= '0;
            if (dispatch) begin
                lane_start_out <= NUM_LANES'(1) << dp;
                lane_v1_out    <= bus.v1_in;
                lane_v2_out    <= bus.v2_in;
                lane_v3_out    <= bus.v3_in;
                id_cnt         <= id_cnt + 1'b1;
                dp             <= dp + 1'b1;
            end
            if (retire) begin
                bus.color_out       <= res[rp];
                bus.tri_id_out      <= id[rp];
                bus.color_valid_out <= 1'b1;
                rp                  <= rp + 1'b1;
            end else if (bus.color_ready_in) begin
                bus.color_valid_out <= 1'b0;
            end
        end
    end

`ifdef SHADER_DISPATCH_PERF_EN
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            perf_tri_count_out   <= '0;
            perf_stall_count_out <= '0;
        end else begin
            if (dispatch && perf_tri_count_out != 32'hFFFF_FFFF) begin
                perf_tri_count_out <= perf_tri_count_out + 32'd1;
            end
            if (bus.tri_valid_in && !bus.tri_ready_out && perf_stall_count_out != 32'hFFFF_FFFF) begin
                perf_stall_count_out <= perf_stall_count_out + 32'd1;
            end
        end
    end
`else
    // The default build carries no performance counters.
`endif

endmodule
